store_capture_queue: RTL and testbench

- Sits between the CPU data-memory write port and the result checker.
- Detects stores to the test port and collapses each store held across D-cache stall cycles into a single event.
- Gates capture with a begin/end session FSM, then buffers captured words in a FIFO with a valid/ready interface toward the checker.
- Decouples the checker from CPU stall timing; the checker then sees exactly one item per architectural store.

---
 rtl/store_capture_pkg.sv | 36 +++
 rtl/store_capture_queue_fifo.sv | 96 +++++++++
 rtl/store_capture_queue.sv | 166 ++++++++++++++++
 tb/tb_store_capture_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/store_capture_pkg.sv
// Shared constants, session state encoding and counter helper for the
// store capture queue.
package store_capture_pkg;

   localparam logic [29:0] DEF_TEST_ADDR = 30'h0000_0040;
   localparam logic [31:0] DEF_BEGIN_SYM = 32'h0000_0932;
   localparam logic [31:0] DEF_END_SYM   = 32'h0000_0D5D;

   // Widest counter the saturating helper supports.
   localparam int unsigned MAX_CNT_W = 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACTIVE = 2'b01,
      S_DONE   = 2'b10
   } session_t;

   // Increment val, sticking at the all-ones value of a width-bit counter.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(
      input logic [MAX_CNT_W-1:0] val,
      input int unsigned          width
   );
      logic [MAX_CNT_W-1:0] max_v;
      if (width >= MAX_CNT_W) begin
         max_v = {MAX_CNT_W{1'b1}};
      end else begin
         max_v = (32'd1 << width) - 32'd1;
      end
      if (val >= max_v) begin
         return val;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/store_capture_queue_fifo.sv
// First-word-fall-through FIFO: the head entry is held in a register so
// dout is a flop output and is valid whenever empty is low.
module sync_fifo_fwft #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_s;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] head_s;
   logic             pop_ok_s;
   logic             push_ok_s;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop_ok_s  = pop && (level_r != {LVL_W{1'b0}});
      push_ok_s = push && ((level_r != LVL_W'(DEPTH)) || pop_ok_s);
   end

   // Next occupancy and next head-register contents.
   always_comb begin
      level_s = level_r;
      head_s  = head_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_s = level_r + LVL_W'(1);
         2'b01:   level_s = level_r - LVL_W'(1);
         default: level_s = level_r;
      endcase
      if (level_r == {LVL_W{1'b0}}) begin
         if (push_ok_s) begin
            head_s = din;
         end else begin
            head_s = head_r;
         end
      end else if (pop_ok_s && (level_r == LVL_W'(1))) begin
         if (push_ok_s) begin
            head_s = din;
         end else begin
            head_s = head_r;
         end
      end else if (pop_ok_s) begin
         head_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end else begin
         head_s = head_r;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         head_r   <= {WIDTH{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         level_r <= level_s;
         head_r  <= head_s;
      end
   end

   assign dout  = head_r;
   assign level = level_r;
   assign full  = (level_r == LVL_W'(DEPTH));
   assign empty = (level_r == {LVL_W{1'b0}});

endmodule

// File: rtl/store_capture_queue.sv
// Turns CPU stores to the test port into one event per architectural store,
// gates them with a begin/end session and queues them for the checker.
module store_capture_queue
   import store_capture_pkg::*;
#(
   parameter logic [29:0] TEST_ADDR = DEF_TEST_ADDR,
   parameter logic [31:0] BEGIN_SYM = DEF_BEGIN_SYM,
   parameter logic [31:0] END_SYM   = DEF_END_SYM,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [29:0]              addr,
   input  logic [31:0]              data,
   input  logic                     wen,
   input  logic                     mem_stall,
   output logic                     out_valid,
   output logic [31:0]              out_data,
   output logic [7:0]               out_idx,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     session_active,
   output logic                     session_done,
   output logic                     overflow,
   output logic [CNT_W-1:0]         capture_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   logic             wen_q_r;
   logic             stall_q_r;
   logic             hit_s;
   logic             new_store_s;
   session_t         state_r;
   session_t         state_s;
   logic             begin_hit_s;
   logic             enq_req_s;
   logic [7:0]       seq_r;
   logic             pop_s;
   logic             drop_s;
   logic             accept_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [39:0]      fifo_dout_s;
   logic             session_active_r;
   logic             session_done_r;
   logic             overflow_r;
   logic [CNT_W-1:0] capture_cnt_r;
   logic [CNT_W-1:0] drop_cnt_r;

   // A store still held by the cache from the previous cycle is not a new event.
   always_comb begin
      hit_s       = wen && (addr == TEST_ADDR);
      new_store_s = hit_s && !(wen_q_r && stall_q_r);
   end

   // Session FSM next state; BEGIN_SYM itself is consumed, not queued.
   always_comb begin
      state_s     = state_r;
      begin_hit_s = 1'b0;
      enq_req_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (new_store_s && (data == BEGIN_SYM)) begin
               state_s     = S_ACTIVE;
               begin_hit_s = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ACTIVE: begin
            if (new_store_s) begin
               enq_req_s = 1'b1;
               if (data == END_SYM) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_ACTIVE;
               end
            end else begin
               state_s = S_ACTIVE;
            end
         end
         S_DONE:  state_s = S_DONE;
         default: state_s = S_IDLE;
      endcase
   end

   // Drops happen only when full and the head is not leaving this cycle.
   always_comb begin
      pop_s    = out_valid && out_ready;
      drop_s   = enq_req_s && fifo_full_s && !pop_s;
      accept_s = enq_req_s && !drop_s;
   end

   // Event-detect history and session state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q_r          <= 1'b0;
         stall_q_r        <= 1'b0;
         state_r          <= S_IDLE;
         session_active_r <= 1'b0;
         session_done_r   <= 1'b0;
      end else begin
         wen_q_r          <= wen;
         stall_q_r        <= mem_stall;
         state_r          <= state_s;
         session_active_r <= (state_s == S_ACTIVE);
         session_done_r   <= (state_s == S_DONE);
      end
   end

   // Sequence number advances on dropped words too, exposing gaps to the checker.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_r <= 8'd0;
      end else if (begin_hit_s) begin
         seq_r <= 8'd0;
      end else if (enq_req_s) begin
         seq_r <= seq_r + 8'd1;
      end else begin
         seq_r <= seq_r;
      end
   end

   // Sticky overflow flag and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r    <= 1'b0;
         capture_cnt_r <= {CNT_W{1'b0}};
         drop_cnt_r    <= {CNT_W{1'b0}};
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= CNT_W'(sat_inc(MAX_CNT_W'(drop_cnt_r), CNT_W));
         end
         if (accept_s) begin
            capture_cnt_r <= CNT_W'(sat_inc(MAX_CNT_W'(capture_cnt_r), CNT_W));
         end
      end
   end

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (40)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (enq_req_s),
      .din   ({seq_r, data}),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (level)
   );

   assign out_valid      = !fifo_empty_s;
   assign out_idx        = fifo_dout_s[39:32];
   assign out_data       = fifo_dout_s[31:0];
   assign session_active = session_active_r;
   assign session_done   = session_done_r;
   assign overflow       = overflow_r;
   assign capture_cnt    = capture_cnt_r;
   assign drop_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_store_capture_queue.sv
// Directed bench for store_capture_queue: a per-cycle vector table followed by
// hand-written overflow, session-end and mid-session reset sequences.
module tb_store_capture_queue;

   localparam logic [29:0] A  = 30'h40;
   localparam logic [29:0] A2 = 30'h41;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] addr = 30'h0;
   logic [31:0] data = 32'h0;
   logic        wen = 1'b0;
   logic        mem_stall = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_data;
   logic [7:0]  out_idx;
   logic [3:0]  level;
   logic        session_active;
   logic        session_done;
   logic        overflow;
   logic [15:0] capture_cnt;
   logic [15:0] drop_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   store_capture_queue dut (
      .clk            (clk),
      .rst            (rst),
      .addr           (addr),
      .data           (data),
      .wen            (wen),
      .mem_stall      (mem_stall),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_idx        (out_idx),
      .out_ready      (out_ready),
      .level          (level),
      .session_active (session_active),
      .session_done   (session_done),
      .overflow       (overflow),
      .capture_cnt    (capture_cnt),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [29:0] addr;
      logic [31:0] data;
      logic        wen;
      logic        stall;
      logic        ready;
      logic        valid;
      logic [31:0] odata;
      logic [7:0]  idx;
      logic [3:0]  lvl;
      logic        act;
      logic        done;
      logic        ovf;
      logic [15:0] cap;
      logic [15:0] drp;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(
      input logic r, input logic [29:0] a, input logic [31:0] d,
      input logic w, input logic s, input logic rd,
      input logic v, input logic [31:0] od, input logic [7:0] ix,
      input logic [3:0] lv, input logic ac, input logic dn, input logic ov,
      input logic [15:0] cp, input logic [15:0] dp);
      vec_t t;
      t.rst = r; t.addr = a; t.data = d; t.wen = w; t.stall = s; t.ready = rd;
      t.valid = v; t.odata = od; t.idx = ix; t.lvl = lv; t.act = ac;
      t.done = dn; t.ovf = ov; t.cap = cp; t.drp = dp;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic cyc(input logic r, input logic [29:0] a, input logic [31:0] d,
                      input logic w, input logic s, input logic rd);
      rst = r; addr = a; data = d; wen = w; mem_stall = s; out_ready = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            rst addr data        wen stl rdy | vld odata      idx lvl act dn ovf cap drp
      vecs[0]  = mk(1, A,  32'h0,      0, 0, 0,   0, 32'h0,     0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, A,  32'h7,      1, 0, 1,   0, 32'h0,     0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, A,  32'h932,    1, 0, 1,   0, 32'h0,     0, 0, 1, 0, 0, 0, 0);
      vecs[3]  = mk(0, A,  32'h0,      1, 0, 1,   1, 32'h0,     0, 1, 1, 0, 0, 1, 0);
      vecs[4]  = mk(0, A,  32'h1,      1, 0, 1,   1, 32'h1,     1, 1, 1, 0, 0, 2, 0);
      vecs[5]  = mk(0, A,  32'h1,      1, 0, 1,   1, 32'h1,     2, 1, 1, 0, 0, 3, 0);
      vecs[6]  = mk(0, A,  32'h2,      1, 0, 1,   1, 32'h2,     3, 1, 1, 0, 0, 4, 0);
      vecs[7]  = mk(0, A,  32'h0,      0, 0, 1,   0, 32'h0,     0, 0, 1, 0, 0, 4, 0);
      vecs[8]  = mk(0, A,  32'h5,      1, 1, 0,   1, 32'h5,     4, 1, 1, 0, 0, 5, 0);
      vecs[9]  = mk(0, A,  32'h5,      1, 1, 0,   1, 32'h5,     4, 1, 1, 0, 0, 5, 0);
      vecs[10] = mk(0, A,  32'h5,      1, 1, 0,   1, 32'h5,     4, 1, 1, 0, 0, 5, 0);
      vecs[11] = mk(0, A,  32'h5,      1, 1, 0,   1, 32'h5,     4, 1, 1, 0, 0, 5, 0);
      vecs[12] = mk(0, A,  32'h5,      1, 0, 0,   1, 32'h5,     4, 1, 1, 0, 0, 5, 0);
      vecs[13] = mk(0, A,  32'h0,      0, 0, 1,   0, 32'h0,     0, 0, 1, 0, 0, 5, 0);
      vecs[14] = mk(0, A2, 32'h7,      1, 0, 1,   0, 32'h0,     0, 0, 1, 0, 0, 5, 0);
      vecs[15] = mk(1, A,  32'h0,      0, 0, 0,   0, 32'h0,     0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].wen, vecs[i].stall, vecs[i].ready);
         check($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].valid));
         check($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].lvl));
         check($sformatf("v%0d.active", i), 32'(session_active), 32'(vecs[i].act));
         check($sformatf("v%0d.done", i), 32'(session_done), 32'(vecs[i].done));
         check($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].ovf));
         check($sformatf("v%0d.capture_cnt", i), 32'(capture_cnt), 32'(vecs[i].cap));
         check($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].drp));
         if (vecs[i].valid) begin
            check($sformatf("v%0d.out_data", i), out_data, vecs[i].odata);
            check($sformatf("v%0d.out_idx", i), 32'(out_idx), 32'(vecs[i].idx));
         end
      end

      // Overflow: ten stores into an eight-entry FIFO with the checker stalled.
      cyc(1, A, 32'h0, 0, 0, 0);
      cyc(0, A, 32'h932, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, A, 32'h100 + 32'(i), 1, 0, 0);
      end
      check("ovf.level", 32'(level), 32'd8);
      check("ovf.overflow", 32'(overflow), 32'd1);
      check("ovf.drop_cnt", 32'(drop_cnt), 32'd2);
      check("ovf.capture_cnt", 32'(capture_cnt), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d.valid", i), 32'(out_valid), 32'd1);
         check($sformatf("drain%0d.idx", i), 32'(out_idx), 32'(i));
         check($sformatf("drain%0d.data", i), out_data, 32'h100 + 32'(i));
         cyc(0, A, 32'h0, 0, 0, 1);
      end
      check("drain.level", 32'(level), 32'd0);
      cyc(0, A, 32'hAB, 1, 0, 0);
      check("gap.valid", 32'(out_valid), 32'd1);
      check("gap.idx", 32'(out_idx), 32'd10);
      check("gap.data", out_data, 32'hAB);
      check("gap.capture_cnt", 32'(capture_cnt), 32'd9);

      // Session end: END_SYM is queued, later stores are ignored.
      cyc(1, A, 32'h0, 0, 0, 0);
      cyc(0, A, 32'h932, 1, 0, 0);
      cyc(0, A, 32'h3, 1, 0, 0);
      cyc(0, A, 32'hD5D, 1, 0, 0);
      cyc(0, A, 32'h9, 1, 0, 0);
      check("end.level", 32'(level), 32'd2);
      check("end.done", 32'(session_done), 32'd1);
      check("end.active", 32'(session_active), 32'd0);
      check("end.capture_cnt", 32'(capture_cnt), 32'd2);
      check("end.head0", out_data, 32'h3);
      check("end.idx0", 32'(out_idx), 32'd0);
      cyc(0, A, 32'h0, 0, 0, 1);
      check("end.head1", out_data, 32'hD5D);
      check("end.idx1", 32'(out_idx), 32'd1);
      cyc(0, A, 32'h0, 0, 0, 1);
      check("end.empty", 32'(out_valid), 32'd0);

      // Reset in the middle of a session flushes the queue and closes the session.
      cyc(1, A, 32'h0, 0, 0, 0);
      cyc(0, A, 32'h932, 1, 0, 0);
      cyc(0, A, 32'h11, 1, 0, 0);
      cyc(0, A, 32'h12, 1, 0, 0);
      cyc(0, A, 32'h13, 1, 0, 0);
      check("mid.level_before", 32'(level), 32'd3);
      cyc(1, A, 32'h0, 0, 0, 0);
      check("mid.level", 32'(level), 32'd0);
      check("mid.valid", 32'(out_valid), 32'd0);
      check("mid.active", 32'(session_active), 32'd0);
      cyc(0, A, 32'h4, 1, 0, 0);
      check("mid.ignored_level", 32'(level), 32'd0);
      check("mid.ignored_active", 32'(session_active), 32'd0);
      check("mid.ignored_cnt", 32'(capture_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
